// File: rtl/ascii_char_fifo_if.sv
// Valid/ready byte stream bundle for the ascii_char_fifo.
// slave is the FIFO side; master is the producer/consumer side.
interface ascii_char_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ascii_char_fifo.sv
// First-word-fall-through byte FIFO with fill level and sticky full flag.
// Optional uppercase letter counter enabled by defining UPPER_STATS_EN.
module ascii_char_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  ascii_char_fifo_if.slave  bus,
  output logic [ADDR_W:0]   level,
`ifdef UPPER_STATS_EN
  output logic [15:0]       upper_cnt,
`endif
  output logic              full_seen
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_seen_q, full_seen_d;
  logic              wr, rd;

  // Handshake flags come only from the registered level.
  always_comb begin
    bus.in_ready  = (level_q != FULL_LVL);
    bus.out_valid = (level_q != '0);
    bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : 8'h00;
    wr            = bus.in_valid & bus.in_ready;
    rd            = bus.out_valid & bus.out_ready;
  end

  assign level     = level_q;
  assign full_seen = full_seen_q;

  // Next pointers, level and sticky flag; a flush wins over any transfer.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    full_seen_d = full_seen_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      full_seen_d = 1'b0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr, rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (bus.in_valid && level_q == FULL_LVL)
        full_seen_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_seen_q <= full_seen_d;
    end
  end

  // Storage array; contents are masked by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr && !clr) mem_q[wr_ptr_q] <= bus.in_data;
  end

`ifdef UPPER_STATS_EN
  logic [15:0] upper_cnt_q, upper_cnt_d;
  logic        is_upper;

  assign is_upper  = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
  assign upper_cnt = upper_cnt_q;

  // Saturating count of accepted 'A'..'Z' bytes.
  always_comb begin
    upper_cnt_d = upper_cnt_q;
    if (clr)
      upper_cnt_d = '0;
    else if (wr && is_upper && upper_cnt_q != 16'hFFFF)
      upper_cnt_d = upper_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upper_cnt_q <= '0;
    else        upper_cnt_q <= upper_cnt_d;
  end
`endif

endmodule

// File: tb/tb_ascii_char_fifo.sv
// Scoreboard bench for ascii_char_fifo: accepted bytes queue up,
// a negedge monitor pops and compares every completed read.
module tb_ascii_char_fifo;
  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] level;
  logic       full_seen;
`ifdef UPPER_STATS_EN
  logic [15:0] upper_cnt;
`endif

  ascii_char_fifo_if bus ();

  ascii_char_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus.slave),
    .level     (level),
`ifdef UPPER_STATS_EN
    .upper_cnt (upper_cnt),
`endif
    .full_seen (full_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare completed reads, record accepted writes.
  always @(negedge clk) begin
    if (rst_n && !clr) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read", int'(bus.out_data), -1);
        end else begin
          check("read_data", int'(bus.out_data), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(bus.in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) tick();
    bus.out_ready = 1'b0;
    check(name, int'(level), 0);
  endtask

  logic [7:0] stream [20] = '{
    8'h54, 8'h48, 8'h45, 8'h20, 8'h51, 8'h55, 8'h49, 8'h43, 8'h4B, 8'h2E,
    8'h30, 8'h31, 8'h7E, 8'h00, 8'hFF, 8'h5A, 8'h61, 8'h41, 8'h0A, 8'h39
  };

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_data", int'(bus.out_data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_level", int'(level), 0);
    check("idle_full_seen", int'(full_seen), 0);
    check("idle_out_valid", int'(bus.out_valid), 0);

    // single byte, FWFT latency
    bus.in_data = 8'h48;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("one_out_valid", int'(bus.out_valid), 1);
    check("one_out_data", int'(bus.out_data), 8'h48);
    check("one_level", int'(level), 1);
    drain("one_drain");

    // fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'h41 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    check("fill_level", int'(level), 8);
    check("fill_in_ready", int'(bus.in_ready), 0);
    check("fill_full_seen_pre", int'(full_seen), 0);
    tick();
    check("fill_full_seen", int'(full_seen), 1);
    drain("fill_drain");
    check("sticky_full_seen", int'(full_seen), 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'h50 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    check("full2_level", int'(level), 8);
    bus.in_data = 8'h58;
    bus.out_ready = 1'b1;
    tick();
    check("full_rd_only", int'(level), 7);
    tick();
    check("full_wr_rd", int'(level), 7);
    drain("full_drain");

    // 20-byte stream with toggling consumer
    begin
      int idx = 0;
      for (int c = 0; c < 200 && idx < 20; c++) begin
        bus.in_data = stream[idx];
        bus.in_valid = 1'b1;
        bus.out_ready = ~bus.out_ready;
        if (bus.in_ready) idx++;
        tick();
      end
      check("stream_sent", idx, 20);
    end
    drain("stream_drain");
    check("stream_scoreboard_empty", exp_q.size(), 0);

    // flush with a write pending
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'h30 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    check("clr_pre_level", int'(level), 5);
    bus.in_data = 8'h77;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("clr_level", int'(level), 0);
    check("clr_out_valid", int'(bus.out_valid), 0);
    check("clr_full_seen", int'(full_seen), 0);

`ifdef UPPER_STATS_EN
    check("cnt_after_clr", int'(upper_cnt), 0);
    begin
      logic [7:0] up [4] = '{8'h41, 8'h7A, 8'h5A, 8'h40};
      for (int i = 0; i < 4; i++) begin
        bus.in_data = up[i];
        bus.in_valid = 1'b1;
        tick();
      end
    end
    bus.in_valid = 1'b0;
    check("upper_cnt", int'(upper_cnt), 2);
    drain("upper_drain");
`endif

    // post-flush traffic still flows
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("post_clr_data", int'(bus.out_data), 8'hA5);
    drain("post_clr_drain");
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
